encoder: RTL and testbench

- HDB3 (High-Density Bipolar order 3) line encoder.
- Takes a serial NRZ bit stream, one bit per clock, and produces a ternary line code on two unipolar rails: P = positive pulse, N = negative pulse.
- Sits between the serial data source and the line driver / bipolar DAC.
- Inserts B00V / 000V substitutions so that no more than 3 consecutive zero symbols appear on the line.

---
 rtl/encoder.sv | 100 ++++++++++
 tb/tb_encoder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/encoder.sv
// HDB3 line encoder: serial NRZ in, bipolar P/N rails out after a fixed 4-clock pipeline.
// The pipeline gives the 4-bit lookahead needed to retro-fit the B pulse of a B00V group.
module encoder #(
  parameter int unsigned DELAY = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic data,
  output logic P,
  output logic N
);

  typedef enum logic [1:0] {
    SymSpace = 2'd0,
    SymMark  = 2'd1,
    SymViol  = 2'd2
  } sym_e;

  sym_e       sym_q [DELAY];
  sym_e       sym_d [DELAY];
  logic [1:0] zcnt_q, zcnt_d;
  logic       odd_q, odd_d;
  logic       last_pos_q, last_pos_d;
  logic       p_q, p_d;
  logic       n_q, n_d;

  // Entry stage: classify the incoming bit and shift the symbol pipeline.
  always_comb begin
    sym_d[0] = SymSpace;
    for (int unsigned i = 1; i < DELAY; i++) begin
      sym_d[i] = sym_q[i - 1];
    end
    zcnt_d = zcnt_q;
    odd_d  = odd_q;

    if (data) begin
      sym_d[0] = SymMark;
      zcnt_d   = 2'd0;
      odd_d    = ~odd_q;
    end else if (zcnt_q != 2'd3) begin
      zcnt_d = zcnt_q + 2'd1;
    end else begin
      sym_d[0] = SymViol;
      zcnt_d   = 2'd0;
      // First zero of the run lands in the last stage on this same edge.
      if (!odd_q) begin
        sym_d[DELAY - 1] = SymMark;
      end
      odd_d = 1'b0;
    end
  end

  // Exit stage: marks alternate polarity, violations repeat the previous one.
  always_comb begin
    p_d        = 1'b0;
    n_d        = 1'b0;
    last_pos_d = last_pos_q;
    case (sym_q[DELAY - 1])
      SymMark: begin
        p_d        = ~last_pos_q;
        n_d        = last_pos_q;
        last_pos_d = ~last_pos_q;
      end
      SymViol: begin
        p_d = last_pos_q;
        n_d = ~last_pos_q;
      end
      default: begin
        p_d = 1'b0;
        n_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DELAY; i++) begin
        sym_q[i] <= SymSpace;
      end
      zcnt_q     <= 2'd0;
      odd_q      <= 1'b0;
      last_pos_q <= 1'b0;
      p_q        <= 1'b0;
      n_q        <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < DELAY; i++) begin
        sym_q[i] <= sym_d[i];
      end
      zcnt_q     <= zcnt_d;
      odd_q      <= odd_d;
      last_pos_q <= last_pos_d;
      p_q        <= p_d;
      n_q        <= n_d;
    end
  end

  assign P = p_q;
  assign N = n_q;

endmodule

// File: tb/tb_encoder.sv
// Scoreboard bench for the HDB3 encoder: a ternary-stream reference model fills an expected
// queue at stimulus time; a monitor pops and compares every output period.
module tb_encoder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic data = 1'b0;
  logic P, N;

  encoder #(.DELAY(4)) dut (
    .clk  (clk),
    .reset(reset),
    .data (data),
    .P    (P),
    .N    (N)
  );

  initial forever #5 clk = ~clk;

  localparam int FillTag = 10;  // expected-queue marker for reset-filled pipeline slots

  int exp_q[$];
  int obs[$];
  int sent[$];
  int m_run, m_marks, m_last;
  int rds, zrun;
  int tests = 0;
  int fails = 0;
  bit armed = 1'b0;

  task automatic fail_line(string name, int act, int req);
    fails++;
    $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // HDB3 rules on the ternary stream (+1/-1/0), in stream order.
  function automatic void model_push(int b);
    if (b != 0) begin
      m_last = -m_last;
      exp_q.push_back(m_last);
      m_run = 0;
      m_marks++;
    end else if (m_run < 3) begin
      exp_q.push_back(0);
      m_run++;
    end else begin
      if (m_marks % 2 == 0) begin
        m_last = -m_last;
        exp_q[exp_q.size() - 3] = m_last;
      end
      exp_q.push_back(m_last);
      m_run   = 0;
      m_marks = 0;
    end
  endfunction

  // Called at a falling edge; returns at a falling edge with reset released.
  task automatic do_reset(string name);
    reset = 1'b0;
    data  = 1'b0;
    #1;
    tests++;
    if (P !== 1'b0 || N !== 1'b0) fail_line(name, {30'd0, P, N}, 0);
    exp_q   = {};
    obs     = {};
    sent    = {};
    m_run   = 0;
    m_marks = 0;
    m_last  = -1;
    rds     = 0;
    zrun    = 0;
    repeat (4) exp_q.push_back(FillTag);
    armed = 1'b1;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic send(int b);
    data = (b != 0);
    model_push(b);
    sent.push_back(b != 0 ? 1 : 0);
    @(negedge clk);
  endtask

  task automatic send_str(string s);
    for (int i = 0; i < s.len(); i++) send(s[i] == "1" ? 1 : 0);
  endtask

  task automatic pad(int k);
    repeat (k) send(0);
  endtask

  task automatic check_seq(string name, string s);
    for (int i = 0; i < s.len(); i++) begin
      int want;
      want = (s[i] == "+") ? 1 : ((s[i] == "-") ? -1 : 0);
      tests++;
      if (i >= obs.size()) fail_line(name, 99, want);
      else if (obs[i] != want) fail_line(name, obs[i], want);
    end
  endtask

  // Independent HDB3 decode: a pulse repeating the previous polarity is V, and a pulse
  // three slots before it is its B.
  task automatic decode_check(string name);
    int dec[$];
    int last;
    last = -1;
    foreach (obs[i]) begin
      if (obs[i] == 0) begin
        dec.push_back(0);
      end else if (obs[i] == last) begin
        dec.push_back(0);
        if (i >= 3) dec[i - 3] = 0;
      end else begin
        dec.push_back(1);
        last = obs[i];
      end
    end
    tests++;
    if (obs.size() < 60) fail_line({name, "_len"}, obs.size(), 60);
    for (int i = 0; i < obs.size() - 3; i++) begin
      tests++;
      if (dec[i] != sent[i]) fail_line(name, dec[i], sent[i]);
    end
  endtask

  // Monitor: one symbol per clock, sampled just after the rising edge.
  initial begin
    int act;
    int e;
    bit is_fill;
    forever begin
      @(posedge clk);
      #1;
      if (armed && reset) begin
        act = P ? 1 : (N ? -1 : 0);
        tests++;
        if (P && N) fail_line("p_and_n", 1, 0);
        tests++;
        if (exp_q.size() == 0) begin
          fail_line("sb_underflow", 0, 1);
        end else begin
          e       = exp_q.pop_front();
          is_fill = (e == FillTag);
          if (is_fill) e = 0;
          if (act != e) fail_line("sb_symbol", act, e);
          if (!is_fill) begin
            obs.push_back(act);
            rds  += act;
            zrun = (act == 0) ? zrun + 1 : 0;
            tests++;
            if (rds > 2 || rds < -2) fail_line("rds_bound", rds, 2);
            tests++;
            if (zrun > 3) fail_line("zero_run", zrun, 3);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    @(negedge clk);
    do_reset("reset_state");
    send_str("0000");
    pad(5);
    check_seq("t1_b00v", "+00+");

    do_reset("reset_t2");
    send_str("1000010000");
    pad(5);
    check_seq("t2_000v", "+000+-000-");

    do_reset("reset_t3");
    send_str("110000");
    pad(5);
    check_seq("t3_even_b00v", "+-+00+");

    do_reset("reset_t4");
    send_str("000000000000");
    pad(5);
    check_seq("t4_alt_v", "+00+-00-+00+");

    do_reset("reset_t5");
    send(1);
    for (int i = 0; i < 10; i++) begin
      if (P === 1'b1) break;
      send(0);
    end
    tests++;
    if (P !== 1'b1) fail_line("mid_p_high", P, 1);
    do_reset("mid_reset_out");
    send_str("00001");
    pad(5);
    check_seq("t5_after_reset", "+00+-");

    do_reset("reset_t6");
    send_str("011000010000000011000011100001111001010001100000000000011100001101");
    pad(8);
    decode_check("t6_decode");

    for (int blk = 0; blk < 6; blk++) begin
      do_reset("rand_reset");
      n = $urandom_range(200, 100);
      for (int i = 0; i < n; i++) begin
        if (blk % 2 == 1 && i == n / 2) do_reset("rand_mid_reset");
        if (blk < 3) send($urandom_range(3) == 0 ? 1 : 0);
        else send($urandom_range(1));
      end
      pad(6);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
